parzen_window_gen: RTL and testbench
====================================

PARZEN_WINDOW_GEN -- requirements
Module: parzen_window_gen

Interface
REQ-001 SHALL have parameter WINDOW_SIZE_POW2, default 10, meaning log2 of window length N (legal range 2..16).
REQ-002 SHALL have parameter OUTPUT_FRAC, default 16, meaning fractional bits of the coefficient output (legal range 8..24).
REQ-003 SHALL have port clk_i  input  1  system clock; one clock, all state on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port start_i  input  1  begin one window sweep.
REQ-006 SHALL have port mode_i  input  2  window shape: 0 Parzen, 1 triangular, 2 or 3 rectangular.
REQ-007 SHALL have port busy_o  output  1  high from accepted start until done.
REQ-008 SHALL have port done_o  output  1  one-cycle pulse at end of sweep.
REQ-009 SHALL have port win_valid_o  output  1  coefficient valid.
REQ-010 SHALL have port win_ready_i  input  1  downstream ready.
REQ-011 SHALL have port win_o  output  OUTPUT_FRAC+1  unsigned Q1.OUTPUT_FRAC coefficient w[n].
REQ-012 SHALL have port idx_o  output  WINDOW_SIZE_POW2  sample index n of win_o.
REQ-013 SHALL have port last_o  output  1  high with the coefficient for n = N-1.

Function
REQ-014 SHALL implement FSM IDLE -> RUN (start_i high in IDLE) -> DRAIN (index N-1 issued) -> IDLE (last coefficient accepted).
REQ-015 SHALL latch mode_i on the accepted start cycle and hold it for the whole sweep.
REQ-016 SHALL ignore start_i while busy_o is high.
REQ-017 SHALL issue indices n = 0..N-1 in order, one per cycle when the pipeline advances, with a counter that stops at N-1 and does not wrap.
REQ-018 SHALL use a 3-stage pipeline (|k|/region, multiply, polynomial/round), advancing only when win_valid_o is low or win_ready_i is high.
REQ-019 SHALL raise win_valid_o with n = 0 exactly 3 cycles after the edge sampling start_i, given win_ready_i held high.
REQ-020 SHALL sustain one coefficient per cycle with win_ready_i held high.
REQ-021 SHALL hold win_o, idx_o and last_o stable while win_valid_o is high and win_ready_i is low.
REQ-022 SHALL compute k = n - N/2, m = |k|, b = m / (N/2), so b is in [0,1] and b = 1 only at n = 0.
REQ-023 SHALL, in Parzen mode, compute w = 1 - 6b^2 + 6b^3 when m <= N/4, otherwise w = 2(1-b)^3.
REQ-024 SHALL, in triangular mode, compute w = 1 - b.
REQ-025 SHALL, in rectangular mode, set w = 1.
REQ-026 SHALL carry the internal arithmetic at full precision (at least 3*(WINDOW_SIZE_POW2-1) fraction bits, signed intermediates), so no intermediate rounding occurs.
REQ-027 SHALL output win_o = floor(w * 2^OUTPUT_FRAC), giving exactly 2^OUTPUT_FRAC for w = 1 and 0 for w = 0.
REQ-028 SHALL assert done_o for one cycle on the cycle after the last_o transfer (win_valid_o and win_ready_i high) and drop busy_o in that same cycle.
REQ-029 SHALL accept a start_i that coincides with done_o high, since the FSM is then in IDLE.

Reset
REQ-030 SHALL, while rst_i is high, immediately clear busy_o, done_o, win_valid_o, last_o, win_o, idx_o, the counter, the pipeline valids and the FSM (to IDLE), independent of clk_i.
REQ-031 SHALL abort a sweep on reset mid-operation with no further coefficients or done_o, and SHALL accept start_i on the first edge after rst_i falls.

Verification
REQ-032 SHALL pass: P=4, F=16, mode 0, ready high, start pulse -> 16 beats; n=0 -> 0, n=2 -> 2048, n=8 -> 65536, n=10 -> 47104, n=12 -> 16384; last_o with n=15; done_o one cycle later.
REQ-033 SHALL pass: P=4, mode 1 -> n=12 gives 32768, n=8 gives 65536, n=0 gives 0; mode 2 -> all 16 beats equal 65536.
REQ-034 SHALL pass: random win_ready_i stalls -> output stable during stalls, no lost or duplicated idx, and win_o equals the floor-exact model for every n.
REQ-035 SHALL pass: start_i pulsed at beat 5 of a sweep -> ignored, exactly 16 beats, mode unchanged.
REQ-036 SHALL pass: rst_i asserted at beat 7 -> outputs zero immediately, no done_o; new start -> full sweep from n=0.
REQ-037 SHALL pass: P=10 mode 0 exhaustive -> all 1024 coefficients match the reference model, and w[n] = w[N-n] for 1 <= n <= N-1.

Source files
------------

// File: rtl/parzen_window_gen.sv
// Streaming window-coefficient generator: Parzen, triangular or rectangular w[n],
// n = 0..N-1. Output is unsigned Q1.OUTPUT_FRAC through a 3-stage valid/ready pipe.
module parzen_window_gen #(
  parameter int WINDOW_SIZE_POW2 = 10,
  parameter int OUTPUT_FRAC      = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [1:0]                  mode_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        win_valid_o,
  input  logic                        win_ready_i,
  output logic [OUTPUT_FRAC:0]        win_o,
  output logic [WINDOW_SIZE_POW2-1:0] idx_o,
  output logic                        last_o
);

  localparam int P  = WINDOW_SIZE_POW2;
  localparam int F  = OUTPUT_FRAC;
  localparam int FB = 3 * (P - 1);  // fraction bits of b^3, with b = m / 2^(P-1)
  localparam int IW = FB + 4;       // room for 6 * 2^FB plus a sign bit

  localparam logic [P-1:0]         HALF    = {1'b1, {(P-1){1'b0}}};
  localparam logic [P-1:0]         QUARTER = HALF >> 1;
  localparam logic [P-1:0]         LAST_N  = '1;
  localparam logic signed [IW-1:0] ONE     = {3'b000, 1'b1, {FB{1'b0}}};
  localparam logic signed [IW-1:0] SIX     = IW'(6);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  // Parzen splits into the cubic core (m <= N/4) and the 2(1-b)^3 tail.
  typedef enum logic [1:0] {SH_CORE, SH_TAIL, SH_TRI, SH_RECT} shape_t;

  state_t     state_q, state_d;
  logic [1:0] mode_q;
  logic [P-1:0] cnt_q;
  logic adv, accept, issue, xfer_last;

  assign adv       = !win_valid_o || win_ready_i;
  assign accept    = (state_q == IDLE) && start_i;
  assign issue     = (state_q == RUN) && adv;
  assign xfer_last = win_valid_o && win_ready_i && last_o;
  assign busy_o    = (state_q != IDLE);

  // NOTE: registered state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (issue && cnt_q == LAST_N) state_d = DRAIN;
      DRAIN:   if (xfer_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q <= 2'd0;
      cnt_q  <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= (state_q == DRAIN) && xfer_last;
      if (accept) begin
        mode_q <= mode_i;
        cnt_q  <= '0;
      end else if (issue && cnt_q != LAST_N) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Stage 1 inputs: m = |n - N/2| and the shape/region for this index.
  logic [P-1:0] m_d;
  shape_t       shape_d;

  always_comb begin
    m_d     = (cnt_q >= HALF) ? (cnt_q - HALF) : (HALF - cnt_q);
    shape_d = SH_RECT;
    case (mode_q)
      2'd0:    shape_d = (m_d <= QUARTER) ? SH_CORE : SH_TAIL;
      2'd1:    shape_d = SH_TRI;
      default: shape_d = SH_RECT;
    endcase
  end

  logic           s1_valid, s1_last;
  logic [P-1:0]   s1_idx, s1_m, d1;
  shape_t         s1_shape;
  logic           s2_valid, s2_last;
  logic [P-1:0]   s2_idx, s2_m, s2_d;
  logic [2*P-1:0] s2_sq, s2_d2;
  shape_t         s2_shape;

  assign d1 = HALF - s1_m;

  // Stage 3: cubes, polynomial, then exact floor to F fraction bits.
  logic [3*P-1:0]        m3, d3;
  logic signed [IW-1:0]  wfix;
  logic [F:0]            win_d;

  assign m3 = (3*P)'(s2_sq) * (3*P)'(s2_m);
  assign d3 = (3*P)'(s2_d2) * (3*P)'(s2_d);

  always_comb begin
    wfix = ONE;
    case (s2_shape)
      SH_CORE: wfix = ONE - SIX * signed'(IW'(s2_sq) << (P - 1)) + SIX * signed'(IW'(m3));
      SH_TAIL: wfix = signed'(IW'(d3)) << 1;
      SH_TRI:  wfix = signed'(IW'(s2_d)) << (2 * (P - 1));
      default: wfix = ONE;
    endcase
  end

  assign win_d = (F+1)'({wfix, {F{1'b0}}} >> FB);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_idx      <= '0;
      s1_m        <= '0;
      s1_shape    <= SH_CORE;
      s2_valid    <= 1'b0;
      s2_last     <= 1'b0;
      s2_idx      <= '0;
      s2_m        <= '0;
      s2_d        <= '0;
      s2_sq       <= '0;
      s2_d2       <= '0;
      s2_shape    <= SH_CORE;
      win_valid_o <= 1'b0;
      win_o       <= '0;
      idx_o       <= '0;
      last_o      <= 1'b0;
    end else if (adv) begin
      s1_valid    <= issue;
      s1_last     <= issue && (cnt_q == LAST_N);
      s1_idx      <= cnt_q;
      s1_m        <= m_d;
      s1_shape    <= shape_d;

      s2_valid    <= s1_valid;
      s2_last     <= s1_last;
      s2_idx      <= s1_idx;
      s2_m        <= s1_m;
      s2_d        <= d1;
      s2_sq       <= (2*P)'(s1_m) * (2*P)'(s1_m);
      s2_d2       <= (2*P)'(d1) * (2*P)'(d1);
      s2_shape    <= s1_shape;

      win_valid_o <= s2_valid;
      win_o       <= win_d;
      idx_o       <= s2_idx;
      last_o      <= s2_last;
    end
  end

endmodule

// File: tb/tb_parzen_window_gen.sv
// Directed bench for parzen_window_gen: N=16 sweeps in every mode with stalls,
// ignored restart, mid-sweep reset, and an exhaustive N=1024 Parzen sweep.
module tb_parzen_window_gen;

  localparam int F = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start4, ready4, busy4, done4, valid4, last4;
  logic [1:0] mode4;
  logic [F:0] win4;
  logic [3:0] idx4;

  logic       start10, ready10, busy10, done10, valid10, last10;
  logic [1:0] mode10;
  logic [F:0] win10;
  logic [9:0] idx10;

  parzen_window_gen #(.WINDOW_SIZE_POW2(4), .OUTPUT_FRAC(F)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .mode_i(mode4),
    .busy_o(busy4), .done_o(done4), .win_valid_o(valid4), .win_ready_i(ready4),
    .win_o(win4), .idx_o(idx4), .last_o(last4)
  );

  parzen_window_gen #(.WINDOW_SIZE_POW2(10), .OUTPUT_FRAC(F)) dut10 (
    .clk_i(clk), .rst_i(rst), .start_i(start10), .mode_i(mode10),
    .busy_o(busy10), .done_o(done10), .win_valid_o(valid10), .win_ready_i(ready10),
    .win_o(win10), .idx_o(idx10), .last_o(last10)
  );

  int     vectors = 0;
  int     miscompares = 0;
  longint got4[16];
  longint got10[1024];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Rational reference: numerator over (N/2)^3, floored by integer division.
  function automatic logic [63:0] model(input int p, input int mode, input int n);
    longint h, m, h3, num;
    h  = longint'(1) << (p - 1);
    m  = (n >= h) ? (n - h) : (h - n);
    h3 = h * h * h;
    if (mode >= 2)       num = h3;
    else if (mode == 1)  num = (h - m) * h * h;
    else if (2 * m <= h) num = h3 - 6 * m * m * h + 6 * m * m * m;
    else                 num = 2 * (h - m) * (h - m) * (h - m);
    return (num << F) / h3;
  endfunction

  // Runs one N=16 sweep after start was driven at the preceding negedge.
  task automatic collect4(input int mode, input int stall_pct, input int poke_beat,
                          input int abort_beat, input bit chain, input int chain_mode);
    int beats = 0;
    int cyc = 0;
    int first_cyc = -1;
    bit stall = 1'b0;
    bit poked = 1'b0;
    bit done_seen = 1'b0;
    logic [F:0] h_win;
    logic [3:0] h_idx;
    logic       h_last;
    while (!done_seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start4 = 1'b0;
      if (cyc == 1) mode4 = ~2'(mode);
      check("busy_in_sweep", busy4, 1);
      check("no_early_done", done4, 0);
      if (stall) begin
        check("stall_valid", valid4, 1);
        check("stall_win", win4, h_win);
        check("stall_idx", idx4, h_idx);
        check("stall_last", last4, h_last);
        stall = 1'b0;
      end
      if (abort_beat >= 0 && beats == abort_beat) begin
        check("pre_abort_valid", valid4, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy4, 0);
        check("abort_done", done4, 0);
        check("abort_valid", valid4, 0);
        check("abort_win", win4, 0);
        check("abort_idx", idx4, 0);
        check("abort_last", last4, 0);
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", done4, 0);
          check("abort_no_valid", valid4, 0);
        end
        rst    = 1'b0;
        start4 = 1'b1;
        mode4  = 2'(chain_mode);
        ready4 = 1'b1;
        return;
      end
      if (poke_beat >= 0 && beats == poke_beat && !poked) begin
        start4 = 1'b1;
        mode4  = 2'd2;
        poked  = 1'b1;
      end
      if (first_cyc < 0 && valid4) begin
        first_cyc = cyc;
        check("first_valid_cycle", first_cyc, 4);
        check("first_idx", idx4, 0);
      end
      ready4 = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
      if (valid4 && ready4) begin
        check("idx", idx4, beats);
        check("win", win4, model(4, mode, beats));
        check("last", last4, beats == 15);
        if (stall_pct == 0) check("no_bubble", cyc, first_cyc + beats);
        got4[beats[3:0]] = win4;
        beats++;
        if (beats == 16) begin
          @(negedge clk);
          check("done_pulse", done4, 1);
          check("busy_drop", busy4, 0);
          if (chain) begin
            start4 = 1'b1;
            mode4  = 2'(chain_mode);
          end else begin
            @(negedge clk);
            check("done_one_cycle", done4, 0);
          end
          done_seen = 1'b1;
        end
      end else if (valid4) begin
        stall  = 1'b1;
        h_win  = win4;
        h_idx  = idx4;
        h_last = last4;
      end
    end
    check("sweep_completes", done_seen, 1);
    check("beat_count", beats, 16);
  endtask

  initial begin
    start4 = 1'b0; mode4 = 2'd0; ready4 = 1'b1;
    start10 = 1'b0; mode10 = 2'd0; ready10 = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_valid", valid4, 0);
    check("rst_win", win4, 0);
    check("rst_idx", idx4, 0);
    check("rst_last", last4, 0);
    @(negedge clk) rst = 1'b0;

    // Parzen, ready high, hand-computed points.
    @(negedge clk); start4 = 1'b1; mode4 = 2'd0;
    collect4(0, 0, -1, -1, 1'b0, 0);
    check("p_n0", got4[0], 0);
    check("p_n2", got4[2], 2048);
    check("p_n8", got4[8], 65536);
    check("p_n10", got4[10], 47104);
    check("p_n12", got4[12], 16384);

    // Triangular, with the next start landing on the done_o cycle.
    @(negedge clk); start4 = 1'b1; mode4 = 2'd1;
    collect4(1, 0, -1, -1, 1'b1, 2);
    check("t_n12", got4[12], 32768);
    check("t_n8", got4[8], 65536);
    check("t_n0", got4[0], 0);

    collect4(2, 0, -1, -1, 1'b0, 0);
    for (int i = 0; i < 16; i++) check("rect_all", got4[i], 65536);

    // Random downstream stalls.
    @(negedge clk); start4 = 1'b1; mode4 = 2'd0;
    collect4(0, 40, -1, -1, 1'b0, 0);

    // Start pulse mid-sweep is ignored.
    @(negedge clk); start4 = 1'b1; mode4 = 2'd1;
    collect4(1, 0, 5, -1, 1'b0, 0);
    repeat (4) begin
      @(negedge clk);
      check("poke_no_restart", busy4, 0);
      check("poke_no_valid", valid4, 0);
    end

    // Reset at beat 7, then restart on the first edge after reset falls.
    @(negedge clk); start4 = 1'b1; mode4 = 2'd3;
    collect4(3, 0, -1, 7, 1'b0, 0);
    collect4(0, 0, -1, -1, 1'b0, 0);

    // Exhaustive N=1024 Parzen sweep with symmetry.
    @(negedge clk); start10 = 1'b1; mode10 = 2'd0; ready10 = 1'b1;
    begin
      int beats = 0;
      int cyc = 0;
      while (beats < 1024 && cyc < 3000) begin
        @(negedge clk);
        cyc++;
        start10 = 1'b0;
        mode10  = 2'd1;
        if (valid10) begin
          check("p10_idx", idx10, beats);
          check("p10_win", win10, model(10, 0, beats));
          check("p10_last", last10, beats == 1023);
          got10[beats[9:0]] = win10;
          beats++;
        end
      end
      check("p10_beats", beats, 1024);
      @(negedge clk);
      check("p10_done", done10, 1);
      for (int n = 1; n < 1024; n++) check("p10_sym", got10[n], got10[1024 - n]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
